// File: rtl/mdio_sched.sv
// MDIO request scheduler: arbitrates host register accesses against a periodic
// link-status poll and hands one request at a time to the MDIO engine.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no request outstanding; arbitration between host and poll
// HOST_BUSY | host request presented on m_*, waiting for m_ready
// POLL_BUSY | status poll presented on m_*, waiting for m_ready
module mdio_sched #(
  parameter int unsigned POLL_INTERVAL = 1000000,
  parameter logic [4:0]  POLL_PHY      = 5'd0,
  parameter logic [4:0]  POLL_REG      = 5'd1,
  parameter int unsigned LINK_BIT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_en,
  input  logic [4:0]  h_phy_addr,
  input  logic [4:0]  h_reg_addr,
  input  logic [15:0] h_wdata,
  input  logic [1:0]  h_op,
  input  logic        h_valid,
  output logic        h_ready,
  output logic [15:0] h_rdata,
  output logic        h_error,
  output logic [4:0]  m_phy_addr,
  output logic [4:0]  m_reg_addr,
  output logic [15:0] m_wdata,
  output logic [1:0]  m_op,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [15:0] m_rdata,
  input  logic        m_error,
  output logic        link_up,
  output logic [15:0] poll_status,
  output logic        poll_valid,
  output logic        poll_err
);

  localparam int unsigned TW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_BUSY = 2'd1,
    POLL_BUSY = 2'd2
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic            poll_pend_q, poll_pend_d;
  logic            last_host_q;

  logic            wrap;
  logic            host_elig;
  logic            poll_elig;
  logic            grant_host;
  logic            grant_poll;

  // Eligibility, tie-break and poll-timer next state.
  always_comb begin
    wrap       = poll_en && (timer_q == TIMER_LAST);
    // h_ready is still high in the cycle after a completion while the host
    // is dropping h_valid, so that cycle must not re-grant the same request.
    host_elig  = h_valid && !h_ready;
    poll_elig  = poll_pend_q && poll_en;
    grant_host = (state_q == IDLE) && host_elig && (!poll_elig || !last_host_q);
    grant_poll = (state_q == IDLE) && poll_elig && (!host_elig || last_host_q);

    timer_d = timer_q + TW'(1);
    if (!poll_en || wrap) begin
      timer_d = '0;
    end

    // A wrap on the same edge as a poll grant is a fresh request and wins.
    poll_pend_d = poll_pend_q;
    if (grant_poll) begin
      poll_pend_d = 1'b0;
    end
    if (wrap) begin
      poll_pend_d = 1'b1;
    end
    if (!poll_en) begin
      poll_pend_d = 1'b0;
    end
  end

  // Poll interval timer and the single pending-poll flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q     <= '0;
      poll_pend_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      poll_pend_q <= poll_pend_d;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_host_q <= 1'b0;
      m_valid     <= 1'b0;
      m_phy_addr  <= '0;
      m_reg_addr  <= '0;
      m_wdata     <= '0;
      m_op        <= '0;
      h_ready     <= 1'b0;
      h_rdata     <= '0;
      h_error     <= 1'b0;
      link_up     <= 1'b0;
      poll_status <= '0;
      poll_valid  <= 1'b0;
      poll_err    <= 1'b0;
    end else begin
      h_ready    <= 1'b0;
      poll_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_host) begin
            m_phy_addr  <= h_phy_addr;
            m_reg_addr  <= h_reg_addr;
            m_wdata     <= h_wdata;
            m_op        <= h_op;
            m_valid     <= 1'b1;
            last_host_q <= 1'b1;
            state_q     <= HOST_BUSY;
          end else if (grant_poll) begin
            m_phy_addr  <= POLL_PHY;
            m_reg_addr  <= POLL_REG;
            m_wdata     <= 16'h0000;
            m_op        <= OP_READ;
            m_valid     <= 1'b1;
            last_host_q <= 1'b0;
            state_q     <= POLL_BUSY;
          end
        end
        HOST_BUSY: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            h_ready <= 1'b1;
            h_rdata <= m_rdata;
            h_error <= m_error;
            state_q <= IDLE;
          end
        end
        POLL_BUSY: begin
          if (m_ready) begin
            m_valid     <= 1'b0;
            poll_valid  <= 1'b1;
            poll_status <= m_rdata;
            poll_err    <= m_error;
            link_up     <= m_error ? 1'b0 : m_rdata[LINK_BIT];
            state_q     <= IDLE;
          end
        end
        default: begin
          m_valid <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_sched.sv
// Scoreboard bench for mdio_sched: a transaction-level reference model predicts
// grants and completions, an engine model answers m_valid, a monitor compares.
module tb_mdio_sched;

  localparam int P = 64;

  logic        clk, rst, poll_en;
  logic [4:0]  h_phy_addr, h_reg_addr;
  logic [15:0] h_wdata;
  logic [1:0]  h_op;
  logic        h_valid, h_ready, h_error;
  logic [15:0] h_rdata;
  logic [4:0]  m_phy_addr, m_reg_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  m_op;
  logic        m_valid, m_ready, m_error;
  logic        link_up, poll_valid, poll_err;
  logic [15:0] poll_status;

  mdio_sched #(.POLL_INTERVAL(P)) dut (
    .clk(clk), .rst(rst), .poll_en(poll_en),
    .h_phy_addr(h_phy_addr), .h_reg_addr(h_reg_addr), .h_wdata(h_wdata),
    .h_op(h_op), .h_valid(h_valid), .h_ready(h_ready), .h_rdata(h_rdata),
    .h_error(h_error), .m_phy_addr(m_phy_addr), .m_reg_addr(m_reg_addr),
    .m_wdata(m_wdata), .m_op(m_op), .m_valid(m_valid), .m_ready(m_ready),
    .m_rdata(m_rdata), .m_error(m_error), .link_up(link_up),
    .poll_status(poll_status), .poll_valid(poll_valid), .poll_err(poll_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [27:0] f; int cyc; } grant_t;
  typedef struct { logic [16:0] d; int cyc; } hdone_t;
  typedef struct { logic [17:0] d; int cyc; } pdone_t;
  typedef struct { logic [15:0] rd; logic er; int lat; } resp_t;

  grant_t exp_grant_q[$];
  hdone_t exp_host_q[$];
  pdone_t exp_poll_q[$];
  resp_t  resp_q[$];
  logic [4:0] grant_log[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int spur_cnt = 0;
  int spur_done = 0;
  bit rand_lat = 0;

  // reference model state
  int md_busy;   // 0 idle, 1 host, 2 poll
  int md_cnt;
  bit md_pend, md_last_host, md_hr, md_link;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event", nm);
  endtask

  // Reference model: what the scheduler should grant and complete, per edge.
  initial begin
    md_busy = 0; md_cnt = 0; md_pend = 0; md_last_host = 0; md_hr = 0; md_link = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        md_busy = 0; md_cnt = 0; md_pend = 0; md_last_host = 0; md_hr = 0; md_link = 0;
        exp_grant_q.delete(); exp_host_q.delete(); exp_poll_q.delete();
      end else begin
        bit wrap, he, pe, gh, gp, new_hr;
        cyc++;
        wrap = poll_en && (md_cnt == P - 1);
        he = h_valid && !md_hr;
        pe = md_pend && poll_en;
        gh = 0; gp = 0; new_hr = 0;
        if (md_busy == 0) begin
          if (he && (!pe || !md_last_host)) gh = 1;
          else if (pe) gp = 1;
        end else if (m_ready) begin
          if (md_busy == 1) begin
            exp_host_q.push_back('{{m_rdata, m_error}, cyc});
            new_hr = 1;
          end else begin
            md_link = m_error ? 1'b0 : m_rdata[2];
            exp_poll_q.push_back('{{m_rdata, m_error, md_link}, cyc});
          end
          md_busy = 0;
        end
        if (gh) begin
          exp_grant_q.push_back('{{h_phy_addr, h_reg_addr, h_wdata, h_op}, cyc});
          md_busy = 1; md_last_host = 1;
        end
        if (gp) begin
          exp_grant_q.push_back('{{5'd0, 5'd1, 16'h0000, 2'b10}, cyc});
          md_busy = 2; md_last_host = 0;
        end
        if (!poll_en) md_pend = 0;
        else if (wrap) md_pend = 1;
        else if (gp) md_pend = 0;
        md_cnt = poll_en ? (md_cnt + 1) % P : 0;
        md_hr = new_hr;
      end
    end
  end

  // MDIO engine model: answers each m_valid after a latency, or pulses a
  // stray m_ready while idle when asked to.
  initial begin
    int e_cnt;
    bit e_busy;
    resp_t r;
    m_ready = 0; m_rdata = 0; m_error = 0; e_busy = 0; e_cnt = 0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) begin
        m_ready = 0; e_busy = 0;
      end else if (m_ready) begin
        m_ready = 0;
      end else if (e_busy) begin
        if (e_cnt <= 1) begin
          m_ready = 1; m_rdata = r.rd; m_error = r.er; e_busy = 0;
        end else begin
          e_cnt--;
        end
      end else if (m_valid) begin
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else begin
          r.rd = 16'($urandom);
          r.er = ($urandom_range(0, 7) == 0);
          r.lat = rand_lat ? int'($urandom_range(1, 20)) : 10;
        end
        e_cnt = r.lat;
        e_busy = 1;
      end else if (spur_cnt != spur_done) begin
        spur_done++;
        m_ready = 1; m_rdata = 16'hDEAD; m_error = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    bit prev_mv;
    grant_t cur;
    prev_mv = 0;
    cur = '{28'h0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mv = 0;
        continue;
      end
      if (m_valid && !prev_mv) begin
        rise_cnt++;
        grant_log.push_back(m_phy_addr);
        if (exp_grant_q.size() == 0) begin
          timeout("unexpected_grant");
        end else begin
          cur = exp_grant_q.pop_front();
          chk("grant_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end
      if (m_valid) chk("m_fields", 64'({m_phy_addr, m_reg_addr, m_wdata, m_op}), 64'(cur.f));
      if (h_ready) begin
        if (exp_host_q.size() == 0) timeout("unexpected_h_ready");
        else begin
          hdone_t e;
          e = exp_host_q.pop_front();
          chk("host_done", 64'({h_rdata, h_error}), 64'(e.d));
          chk("host_done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (poll_valid) begin
        if (exp_poll_q.size() == 0) timeout("unexpected_poll_valid");
        else begin
          pdone_t e;
          e = exp_poll_q.pop_front();
          chk("poll_done", 64'({poll_status, poll_err, link_up}), 64'(e.d));
          chk("poll_done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_mv = m_valid;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pvalid(input string nm);
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk); #1;
      if (poll_valid) seen = 1;
    end
    if (!seen) timeout(nm);
  endtask

  task automatic wait_pend(input string nm);
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk); #1;
      if (md_pend) seen = 1;
    end
    if (!seen) timeout(nm);
  endtask

  task automatic host_start(input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd, input logic [1:0] op);
    h_phy_addr = phy; h_reg_addr = rg; h_wdata = wd; h_op = op; h_valid = 1;
  endtask

  task automatic host_finish(input string nm);
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk); #1;
      if (h_ready) seen = 1;
    end
    h_valid = 0;
    if (!seen) timeout(nm);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_m"}, 64'({m_valid, m_phy_addr, m_reg_addr, m_wdata, m_op}), 64'h0);
    chk({nm, "_h"}, 64'({h_ready, h_rdata, h_error}), 64'h0);
    chk({nm, "_link_up"}, 64'(link_up), 64'h0);
    chk({nm, "_poll"}, 64'({poll_status, poll_valid, poll_err}), 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rbase;
    rst = 1; poll_en = 0; h_valid = 0;
    h_phy_addr = 0; h_reg_addr = 0; h_wdata = 0; h_op = 0;
    wait_cyc(3);
    chk_all_zero("reset");
    rst = 0;
    wait_cyc(2);

    // tie right after reset: host first, then poll (link bit clear)
    poll_en = 1;
    resp_q.push_back('{16'h0141, 1'b0, 10});
    resp_q.push_back('{16'h7849, 1'b0, 10});
    wait_pend("pend_after_reset");
    base = grant_log.size();
    host_start(5'd3, 5'd2, 16'h0000, 2'b10);
    host_finish("host_read");
    chk("host_read_rdata", 64'({h_rdata, h_error}), 64'({16'h0141, 1'b0}));
    wait_pvalid("poll_7849");
    chk("poll_7849", 64'({poll_status, poll_err, link_up}), 64'({16'h7849, 1'b0, 1'b0}));
    chk("tie1_first", 64'(grant_log[base]), 64'd3);
    chk("tie1_second", 64'(grant_log[base + 1]), 64'd0);

    // host alone, then a tie with last grant = host: poll first (link set)
    resp_q.push_back('{16'h0000, 1'b0, 10});
    host_start(5'd5, 5'd9, 16'hABCD, 2'b01);
    host_finish("host_write");
    wait_pend("pend_tie2");
    resp_q.push_back('{16'h786D, 1'b0, 10});
    resp_q.push_back('{16'h1111, 1'b0, 10});
    base = grant_log.size();
    host_start(5'd6, 5'd4, 16'h0000, 2'b10);
    wait_pvalid("poll_786d");
    chk("poll_786d_link", 64'(link_up), 64'd1);
    host_finish("host_after_poll");
    chk("tie2_first", 64'(grant_log[base]), 64'd0);
    chk("tie2_second", 64'(grant_log[base + 1]), 64'd6);

    // poll error
    resp_q.push_back('{16'hFFFF, 1'b1, 10});
    wait_pvalid("poll_err");
    chk("poll_err", 64'({poll_status, poll_err, link_up}), 64'({16'hFFFF, 1'b1, 1'b0}));

    // long host transaction spans two wraps: exactly one poll follows
    resp_q.push_back('{16'h2222, 1'b0, 150});
    host_start(5'd1, 5'd3, 16'h0000, 2'b10);
    host_finish("host_long");
    rbase = rise_cnt;
    wait_cyc(11);
    chk("overlap_grants", 64'(rise_cnt - rbase), 64'd1);
    chk("overlap_is_poll", 64'(grant_log[grant_log.size() - 1]), 64'd0);

    // poll_en dropped mid-count; stray m_ready while idle is ignored
    wait_pvalid("poll_before_disable");
    wait_cyc(20);
    poll_en = 0;
    rbase = rise_cnt;
    wait_cyc(5);
    spur_cnt++;
    wait_cyc(200);
    chk("disabled_grants", 64'(rise_cnt - rbase), 64'd0);
    chk("disabled_link_kept", 64'(link_up), 64'(md_link));

    // reset five cycles into a poll
    poll_en = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(posedge clk); #1;
        if (m_valid) seen = 1;
      end
      if (!seen) timeout("poll_before_reset");
    end
    wait_cyc(5);
    rst = 1;
    #1;
    chk_all_zero("mid_reset");
    wait_cyc(3);
    rst = 0;
    wait_pend("pend_after_midreset");
    base = grant_log.size();
    host_start(5'd7, 5'd7, 16'h0000, 2'b10);
    host_finish("host_after_midreset");
    chk("midreset_tie_first", 64'(grant_log[base]), 64'd7);

    // randomized traffic
    rand_lat = 1;
    for (int t = 0; t < 40; t++) begin
      wait_cyc(int'($urandom_range(0, 40)));
      if ($urandom_range(0, 5) == 0) poll_en = ~poll_en;
      host_start(5'($urandom), 5'($urandom), 16'($urandom),
                 ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      host_finish("host_rand");
    end
    poll_en = 0;
    wait_cyc(100);
    chk("drain_grants", 64'(exp_grant_q.size()), 64'd0);
    chk("drain_host", 64'(exp_host_q.size()), 64'd0);
    chk("drain_poll", 64'(exp_poll_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_sched.md
MDIO_SCHED -- requirements
Module: mdio_sched

Interface
REQ-001 The block SHALL have parameter POLL_INTERVAL, default 1000000, meaning clk cycles between automatic status polls (minimum 2).
REQ-002 The block SHALL have parameter POLL_PHY, default 5'd0, meaning the PHY address used by the poller.
REQ-003 The block SHALL have parameter POLL_REG, default 5'd1, meaning the register address used by the poller.
REQ-004 The block SHALL have parameter LINK_BIT, default 2, meaning the bit of the polled register that reports link status.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  clock
  rst  in  1  reset; asynchronous, active-high
  poll_en  in  1  enables the periodic poll timer
  h_phy_addr  in  5  host PHY address
  h_reg_addr  in  5  host register address
  h_wdata  in  16  host write data
  h_op  in  2  host opcode (2'b10 read, 2'b01 write)
  h_valid  in  1  host request; held with stable fields until h_ready
  h_ready  out  1  one-cycle host completion pulse
  h_rdata  out  16  host read data; valid with h_ready
  h_error  out  1  host error flag; valid with h_ready
  m_phy_addr  out  5  PHY address to the MDIO engine
  m_reg_addr  out  5  register address to the MDIO engine
  m_wdata  out  16  write data to the MDIO engine
  m_op  out  2  opcode to the MDIO engine
  m_valid  out  1  request to the MDIO engine
  m_ready  in  1  one-cycle completion pulse from the MDIO engine
  m_rdata  in  16  read data from the MDIO engine
  m_error  in  1  error flag from the MDIO engine
  link_up  out  1  latest link status
  poll_status  out  16  latest polled register value
  poll_valid  out  1  one-cycle pulse when poll_status updates
  poll_err  out  1  error flag of the latest poll

Function
REQ-006 The FSM SHALL have states IDLE, HOST_BUSY and POLL_BUSY; all outputs are registered.
REQ-007 Poll timer: counts 0..POLL_INTERVAL-1 and wraps while poll_en=1; on the wrap it sets poll_pend.
- If poll_pend is already set at a wrap, it stays set; requests are not queued.
REQ-008 poll_en=0 SHALL hold the timer at 0 and clear poll_pend; link_up, poll_status and poll_err keep their values; an in-flight poll completes normally.
REQ-009 Host eligibility in IDLE: h_valid=1 and h_ready=0.
REQ-010 Arbitration in IDLE:
- only one eligible: grant it;
- both eligible: grant the side not granted last; last_grant resets to POLL, so host wins the first tie.
REQ-011 At grant: m_phy_addr/m_reg_addr/m_wdata/m_op are latched from the host fields, or from {POLL_PHY, POLL_REG, 16'h0, 2'b10} for a poll; m_valid <= 1; the FSM moves to HOST_BUSY/POLL_BUSY; a poll grant clears poll_pend.
- m_valid is high the cycle after the grant edge.
REQ-012 m_valid and the m_* fields SHALL stay stable while busy; m_valid clears on the edge where m_ready=1 is sampled, and the FSM returns to IDLE on that same edge.
REQ-013 The earliest next grant is the cycle after return to IDLE.
REQ-014 Host completion: on m_ready in HOST_BUSY, the next cycle has h_ready=1 for exactly one cycle, with h_rdata=m_rdata and h_error=m_error held until the next host completion.
REQ-015 Poll completion: on m_ready in POLL_BUSY, the next cycle has:
- poll_valid=1 for one cycle;
- poll_status=m_rdata and poll_err=m_error;
- link_up=m_rdata[LINK_BIT] if m_error=0, otherwise 0.
REQ-016 m_ready seen in IDLE SHALL be ignored.
REQ-017 A timer wrap during POLL_BUSY or HOST_BUSY SHALL set poll_pend, serviced after the current transaction.
REQ-018 Changes to h_valid while not granted SHALL have no effect on m_*.

Reset
REQ-019 rst=1 SHALL asynchronously force:
- FSM=IDLE, timer=0, poll_pend=0, last_grant=POLL;
- m_valid=0, m_phy_addr=0, m_reg_addr=0, m_wdata=0, m_op=0;
- h_ready=0, h_rdata=0, h_error=0;
- link_up=0, poll_status=0, poll_valid=0, poll_err=0.
REQ-020 Reset mid-transaction SHALL abandon it without completion pulses; the bench also resets the MDIO engine.

Verification (POLL_INTERVAL=64, engine model returns m_ready 10 cycles after m_valid)
REQ-021 Host read: h_valid, h_op=10, h_phy_addr=3, h_reg_addr=2; model returns 16'h0141 -> m_phy_addr=3, m_reg_addr=2, m_op=10 latched; h_ready one pulse with h_rdata=16'h0141, h_error=0.
REQ-022 Poll with link: poll_en=1, model returns 16'h7849 -> m_phy_addr=0, m_reg_addr=1, m_op=10; poll_valid pulse; poll_status=16'h7849, link_up=0; with 16'h786D -> link_up=1.
REQ-023 Tie: h_valid and poll_pend both eligible in the same IDLE cycle after reset -> host first, then poll; at the next tie with last_grant=HOST -> poll first.
REQ-024 Poll error: model returns m_error=1, rdata=16'hFFFF -> poll_err=1, link_up=0, poll_status=16'hFFFF.
REQ-025 Overlap: timer wraps twice during a 150-cycle host transaction -> exactly one poll follows; poll_en=0 mid-count -> no poll grant and link_up retained.
REQ-026 Reset mid-poll: assert rst 5 cycles after m_valid -> all outputs zero, no poll_valid pulse, next grant goes to host on a tie.
